// File: rtl/tetris_pkg.sv
// Shared definitions for the tetris VGA drawing path.
// Contents: screen geometry, pixel coordinate widths, command op encodings,
// FSM state encoding, colour constants and a cell-origin helper.
package tetris_pkg;

  localparam int unsigned SCREEN_W    = 160;
  localparam int unsigned SCREEN_H    = 120;
  localparam int unsigned NX          = 8;
  localparam int unsigned NY          = 7;
  localparam int unsigned COLOR_DEPTH = 9;

  // Command opcodes as carried on req_op.
  typedef enum logic {
    OP_CELL  = 1'b0,
    OP_CLEAR = 1'b1
  } op_e;

  // Painter FSM states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CELL  = 2'd1,
    ST_CLEAR = 2'd2
  } state_e;

  // Colours are {R[2:0], G[2:0], B[2:0]}.
  localparam logic [COLOR_DEPTH-1:0] COLOR_BLACK = 9'h000;
  localparam logic [COLOR_DEPTH-1:0] COLOR_BG    = 9'h049;

  // Pixel coordinate of a cell's top/left edge: base + idx << sh, in NX bits.
  // Callers truncate to NY bits for the vertical axis.
  function automatic logic [NX-1:0] cell_origin(input int unsigned base,
                                                input logic [3:0]  idx,
                                                input int unsigned sh);
    return NX'(base) + (NX'(idx) << sh);
  endfunction

endpackage

// File: rtl/pixel_scan_counter.sv
// 2-D raster scan counter shared by the cell fill and the screen clear.
// Ports:
//   clock, resetn     : clock and synchronous active-low reset
//   start             : restart at (0,0) and capture x_max/y_max
//   x_max, y_max      : last inner/outer index of the scan (width-1, height-1)
//   step              : advance one position, inner counter first
//   next_x_c/next_y_c : position the counter moves to on the next step
//   last              : current position is (x_max, y_max)
module pixel_scan_counter
  import tetris_pkg::*;
#(
  parameter int unsigned XW = NX,
  parameter int unsigned YW = NY
) (
  input  logic          clock,
  input  logic          resetn,
  input  logic          start,
  input  logic [XW-1:0] x_max,
  input  logic [YW-1:0] y_max,
  input  logic          step,
  output logic [XW-1:0] next_x_c,
  output logic [YW-1:0] next_y_c,
  output logic          last
);

  logic [XW-1:0] cx;
  logic [YW-1:0] cy;
  logic [XW-1:0] xm;
  logic [YW-1:0] ym;
  logic          wrap_x;

  // Inner counter wraps to 0 and carries into the outer one.
  always_comb begin
    wrap_x   = (cx == xm);
    next_x_c = wrap_x ? '0 : cx + XW'(1);
    next_y_c = cy;
    if (wrap_x) begin
      next_y_c = (cy == ym) ? '0 : cy + YW'(1);
    end
  end

  // Position and bounds registers; last is registered alongside the position.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      cx   <= '0;
      cy   <= '0;
      xm   <= '0;
      ym   <= '0;
      last <= 1'b0;
    end else if (start) begin
      cx   <= '0;
      cy   <= '0;
      xm   <= x_max;
      ym   <= y_max;
      last <= (x_max == '0) && (y_max == '0);
    end else if (step) begin
      cx   <= next_x_c;
      cy   <= next_y_c;
      last <= (next_x_c == xm) && (next_y_c == ym);
    end
  end

endmodule

// File: rtl/tetris_cell_painter.sv
// Pixel-write initiator for the 160x120 VGA adapter frame buffer.
// Takes one command at a time (fill one board cell or clear the screen) and
// streams one pixel write per clock.
// Ports:
//   clock, resetn        : clock and synchronous active-low reset
//   req_valid/req_ready  : command handshake
//   req_op               : 0 fill cell, 1 clear screen
//   req_col/req_row      : board cell (ignored for clear)
//   req_color            : fill colour {R,G,B} 3 bits each
//   x, y, color, write   : pixel stream to vga_adapter
//   done                 : one-cycle pulse when a command completes
module tetris_cell_painter
  import tetris_pkg::*;
#(
  parameter int unsigned CELL     = 8,
  parameter int unsigned COLS     = 10,
  parameter int unsigned ROWS     = 15,
  parameter int unsigned BOARD_X0 = 40,
  parameter int unsigned BOARD_Y0 = 0
) (
  input  logic                   clock,
  input  logic                   resetn,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_op,
  input  logic [3:0]             req_col,
  input  logic [3:0]             req_row,
  input  logic [COLOR_DEPTH-1:0] req_color,
  output logic [NX-1:0]          x,
  output logic [NY-1:0]          y,
  output logic [COLOR_DEPTH-1:0] color,
  output logic                   write,
  output logic                   done
);

  localparam int unsigned CELL_SH = $clog2(CELL);

  // Board geometry must fit on screen and cells must be a power of two.
  if ((BOARD_X0 + COLS * CELL) > SCREEN_W) begin : g_bad_width
    $error("tetris_cell_painter: board exceeds screen width");
  end
  if ((BOARD_Y0 + ROWS * CELL) > SCREEN_H) begin : g_bad_height
    $error("tetris_cell_painter: board exceeds screen height");
  end
  if ((CELL == 0) || ((CELL & (CELL - 1)) != 0)) begin : g_bad_cell
    $error("tetris_cell_painter: CELL must be a power of two");
  end

  state_e        state;
  logic [NX-1:0] base_x;
  logic [NY-1:0] base_y;

  logic          accept;
  logic          is_clear;
  logic          in_range;
  logic [NX-1:0] cell_x;
  logic [NY-1:0] cell_y;
  logic [NX-1:0] scan_xmax;
  logic [NY-1:0] scan_ymax;
  logic          scan_start;
  logic          scan_step;
  logic          scan_last;
  logic [NX-1:0] scan_next_x;
  logic [NY-1:0] scan_next_y;

  // Command decode, only meaningful in the accepting cycle.
  assign accept    = (state == ST_IDLE) && req_valid;
  assign is_clear  = (req_op == OP_CLEAR);
  assign in_range  = (32'(req_col) < COLS) && (32'(req_row) < ROWS);
  assign cell_x    = cell_origin(BOARD_X0, req_col, CELL_SH);
  assign cell_y    = NY'(cell_origin(BOARD_Y0, req_row, CELL_SH));
  assign scan_xmax = is_clear ? NX'(SCREEN_W - 1) : NX'(CELL - 1);
  assign scan_ymax = is_clear ? NY'(SCREEN_H - 1) : NY'(CELL - 1);

  // Out-of-range cells never start the scanner.
  assign scan_start = accept && (is_clear || in_range);
  assign scan_step  = (state != ST_IDLE) && !scan_last;

  pixel_scan_counter #(
    .XW (NX),
    .YW (NY)
  ) u_scan (
    .clock    (clock),
    .resetn   (resetn),
    .start    (scan_start),
    .x_max    (scan_xmax),
    .y_max    (scan_ymax),
    .step     (scan_step),
    .next_x_c (scan_next_x),
    .next_y_c (scan_next_y),
    .last     (scan_last)
  );

  // Painter FSM; the first pixel is driven on the accepting edge so write
  // is high in the very next cycle, and later pixels come from the
  // scanner's next position so x/y stay registered without a lag cycle.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state     <= ST_IDLE;
      req_ready <= 1'b1;
      write     <= 1'b0;
      done      <= 1'b0;
      x         <= '0;
      y         <= '0;
      color     <= '0;
      base_x    <= '0;
      base_y    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (is_clear) begin
              state     <= ST_CLEAR;
              req_ready <= 1'b0;
              write     <= 1'b1;
              x         <= '0;
              y         <= '0;
              color     <= req_color;
              base_x    <= '0;
              base_y    <= '0;
            end else if (in_range) begin
              state     <= ST_CELL;
              req_ready <= 1'b0;
              write     <= 1'b1;
              x         <= cell_x;
              y         <= cell_y;
              color     <= req_color;
              base_x    <= cell_x;
              base_y    <= cell_y;
            end else begin
              // Accepted but nothing to draw: complete immediately.
              done <= 1'b1;
            end
          end
        end
        ST_CELL, ST_CLEAR: begin
          if (scan_last) begin
            state     <= ST_IDLE;
            req_ready <= 1'b1;
            write     <= 1'b0;
            done      <= 1'b1;
          end else begin
            x <= base_x + scan_next_x;
            y <= base_y + scan_next_y;
          end
        end
        default: begin
          state     <= ST_IDLE;
          req_ready <= 1'b1;
          write     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tetris_cell_painter.sv
// Scoreboard bench for tetris_cell_painter: directed commands push expected
// pixels and done cycles into queues; a monitor pops and compares them.
module tb_tetris_cell_painter;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic       req_op = 1'b0;
  logic [3:0] req_col = '0;
  logic [3:0] req_row = '0;
  logic [8:0] req_color = '0;
  logic [7:0] x;
  logic [6:0] y;
  logic [8:0] color;
  logic       write;
  logic       done;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    int x;
    int y;
    int c;
    int cyc;
  } pix_t;

  pix_t pq[$];
  int   dq[$];
  pix_t mon_p;
  int   mon_d;

  tetris_cell_painter dut (
    .clock     (clock),
    .resetn    (resetn),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_col   (req_col),
    .req_row   (req_row),
    .req_color (req_color),
    .x         (x),
    .y         (y),
    .color     (color),
    .write     (write),
    .done      (done)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Monitor: every presented pixel and every done pulse is matched in order.
  always @(negedge clock) begin
    if (write === 1'b1) begin
      checks++;
      if (pq.size() == 0) begin
        failures++;
        $display("FAIL pixel_unexpected actual=(%0d,%0d) cyc=%0d expected=none", x, y, cyc);
      end else begin
        mon_p = pq.pop_front();
        if (int'(x) != mon_p.x || int'(y) != mon_p.y || int'(color) != mon_p.c || cyc != mon_p.cyc) begin
          failures++;
          $display("FAIL pixel actual=(%0d,%0d,%03h)@%0d expected=(%0d,%0d,%03h)@%0d",
                   x, y, color, cyc, mon_p.x, mon_p.y, mon_p.c, mon_p.cyc);
        end
      end
      checks++;
      if (req_ready !== 1'b0) begin
        failures++;
        $display("FAIL ready_during_write actual=%b expected=0 cyc=%0d", req_ready, cyc);
      end
    end
    if (done === 1'b1) begin
      checks++;
      if (dq.size() == 0) begin
        failures++;
        $display("FAIL done_unexpected actual=done@%0d expected=none", cyc);
      end else begin
        mon_d = dq.pop_front();
        if (cyc != mon_d) begin
          failures++;
          $display("FAIL done_cycle actual=%0d expected=%0d", cyc, mon_d);
        end
      end
    end
  end

  // Issue one command at a negedge; returns at the negedge of the first
  // cycle after acceptance (cyc == acc). maxpix truncates expectations.
  task automatic send(input logic op, input logic [3:0] col, input logic [3:0] row,
                      input logic [8:0] colr, input int maxpix, input bit exp_done,
                      input bit hold, output int acc);
    int   b = 0;
    int   n = 0;
    pix_t p;
    req_op    = op;
    req_col   = col;
    req_row   = row;
    req_color = colr;
    req_valid = 1'b1;
    while (req_ready !== 1'b1 && b < 30000) begin
      @(negedge clock);
      b++;
    end
    chk("accept_ready", {31'd0, req_ready}, 32'd1);
    acc = cyc + 1;
    if (op) begin
      for (int i = 0; i < 19200; i++) begin
        if (n < maxpix) begin
          p.x = i % 160; p.y = i / 160; p.c = int'(colr); p.cyc = acc + i;
          pq.push_back(p);
          n++;
        end
      end
    end else if (int'(col) < 10 && int'(row) < 15) begin
      for (int i = 0; i < 64; i++) begin
        if (n < maxpix) begin
          p.x = 40 + int'(col) * 8 + i % 8; p.y = int'(row) * 8 + i / 8;
          p.c = int'(colr); p.cyc = acc + i;
          pq.push_back(p);
          n++;
        end
      end
    end
    if (exp_done) dq.push_back(acc + n);
    @(negedge clock);
    if (!hold) req_valid = 1'b0;
  endtask

  task automatic drain(input int bound);
    int b = 0;
    while ((pq.size() != 0 || dq.size() != 0) && b < bound) begin
      @(negedge clock);
      b++;
    end
    chk("drain_empty", 32'(pq.size() + dq.size()), 32'd0);
    @(negedge clock);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_write"}, {31'd0, write}, 32'd0);
    chk({tag, "_done"}, {31'd0, done}, 32'd0);
    chk({tag, "_ready"}, {31'd0, req_ready}, 32'd1);
    chk({tag, "_x"}, {24'd0, x}, 32'd0);
    chk({tag, "_y"}, {25'd0, y}, 32'd0);
    chk({tag, "_color"}, {23'd0, color}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    int acc1;
    int acc2;

    // Reset, then idle.
    repeat (3) @(negedge clock);
    resetn = 1'b1;
    repeat (10) @(negedge clock);
    chk_reset_outputs("idle");

    // Single cell at the board origin.
    send(1'b0, 4'd0, 4'd0, 9'h1C0, 100000, 1'b1, 1'b0, acc);
    drain(200);

    // Bottom-right cell then (3,2) back to back with req_valid held.
    send(1'b0, 4'd9, 4'd14, 9'h03F, 100000, 1'b1, 1'b1, acc1);
    send(1'b0, 4'd3, 4'd2, 9'h1FF, 100000, 1'b1, 1'b0, acc2);
    chk("b2b_accept_cycle", 32'(acc2), 32'(acc1 + 65));
    drain(200);

    // Out-of-range column: no writes, done one cycle after acceptance.
    send(1'b0, 4'd10, 4'd0, 9'h0AA, 100000, 1'b1, 1'b0, acc);
    chk("oor_ready_done_cycle", {31'd0, req_ready}, 32'd1);
    chk("oor_done_pulse", {31'd0, done}, 32'd1);
    @(negedge clock);
    chk("oor_ready_after", {31'd0, req_ready}, 32'd1);
    chk("oor_done_clears", {31'd0, done}, 32'd0);
    drain(10);

    // Full-screen clear with a stray request pulse that must be ignored.
    send(1'b1, 4'd0, 4'd0, 9'h000, 100000, 1'b1, 1'b0, acc);
    repeat (5) @(negedge clock);
    req_op = 1'b0; req_col = 4'd1; req_row = 4'd1; req_color = 9'h1FF;
    req_valid = 1'b1;
    repeat (3) @(negedge clock);
    req_valid = 1'b0;
    drain(20000);

    // Reset while pixel 20 of a cell fill is on the bus.
    send(1'b0, 4'd5, 4'd5, 9'h0AA, 21, 1'b0, 1'b0, acc);
    repeat (20) @(negedge clock);
    resetn = 1'b0;
    @(negedge clock);
    chk_reset_outputs("midreset");
    resetn = 1'b1;
    repeat (5) @(negedge clock);
    chk("midreset_no_pending", 32'(pq.size() + dq.size()), 32'd0);

    // A fresh command completes normally after the reset.
    send(1'b0, 4'd1, 4'd1, 9'h155, 100000, 1'b1, 1'b0, acc);
    drain(200);
    chk("final_ready", {31'd0, req_ready}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tetris_cell_painter.md
# tetris_cell_painter

Pixel-write initiator for the 160x120, 9-bit-colour VGA adapter frame buffer. Accepts one drawing command at a time (fill one board cell, or clear the whole screen) and emits the adapter's `x`/`y`/`color`/`write` stream, one pixel per clock. It sits between the game logic and `vga_adapter`, replacing the tied-off pixel port of the demo top.

## Interface

**Parameters**

- `CELL`, default 8: cell edge in pixels; must be a power of two.
- `COLS`, default 10: board width in cells.
- `ROWS`, default 15: board height in cells.
- `BOARD_X0`, default 40: pixel x of the board's left edge.
- `BOARD_Y0`, default 0: pixel y of the board's top edge.
- Elaboration error unless `BOARD_X0+COLS*CELL <= 160` and `BOARD_Y0+ROWS*CELL <= 120`.

**Ports**

- `clock`  in  1: system clock, CLOCK_50 domain.
- `resetn`  in  1: reset, synchronous, active-low.
- `req_valid`  in  1: command present.
- `req_ready`  out  1: block can accept a command.
- `req_op`  in  1: 0 = fill cell, 1 = clear screen.
- `req_col`  in  4: cell column; ignored when `req_op`=1.
- `req_row`  in  4: cell row; ignored when `req_op`=1.
- `req_color`  in  9: fill colour, {R[2:0],G[2:0],B[2:0]}.
- `x`  out  8: pixel x to adapter.
- `y`  out  7: pixel y to adapter.
- `color`  out  9: pixel colour to adapter.
- `write`  out  1: pixel write strobe to adapter.
- `done`  out  1: one-cycle pulse when a command completes.

## Operation

- FSM states:
  - IDLE: `req_ready`=1.
  - CELL: fills one cell.
  - CLEAR: fills the whole screen.
- A command is accepted on a rising edge where `req_valid && req_ready`. On acceptance, `req_op`, `req_col`, `req_row` and `req_color` are latched. Inputs are ignored at all other times.
- **CELL**
  - Scan is raster order within the cell: `dx` is the inner counter (0..CELL-1), `dy` the outer.
  - Each cycle: `x = BOARD_X0 + col*CELL + dx`, `y = BOARD_Y0 + row*CELL + dy`, `write`=1.
  - After pixel (CELL-1, CELL-1), the FSM returns to IDLE.
- **CLEAR**
  - Scan x 0..159 inner, y 0..119 outer, with the latched colour and `write`=1 every cycle.
- **Out-of-range cell** (`col>=COLS` or `row>=ROWS`): the command is accepted, no write is issued, `done` pulses one cycle after acceptance, and the FSM stays in IDLE.
- `done` asserts in the cycle the FSM re-enters IDLE.
- Back-to-back commands are legal: with `req_valid` held high, the next command is accepted on the edge that ends the `done` cycle.
- **Widths**
  - Offsets are computed as `col*CELL` by left shift (log2 CELL).
  - x sums are 8-bit, y sums 7-bit. The parameter check guarantees no overflow.
- **Reset**
  - `resetn` low at any edge (including mid-fill): FSM→IDLE, scan counters cleared, the command is abandoned, and no `done` is issued for it.

## Timing

- All outputs are registered.
- Reset values: `req_ready`=1, `write`=0, `done`=0, `x`=0, `y`=0, `color`=0.
- When `write`=0, `x`/`y`/`color` hold their last driven values.
- Command accepted at edge k:
  - First pixel is presented in cycle k+1.
  - CELL: `write` high for cycles k+1..k+CELL², `done` and `req_ready` high in cycle k+CELL²+1 (k+65 at default).
  - CLEAR: 19200 write cycles, `done` in cycle k+19201.
- `req_ready`=0 from cycle k+1 until the `done` cycle.
- `write` never has gaps within a command.

## Structure

- Shared package `tetris_pkg`:
  - `SCREEN_W`=160, `SCREEN_H`=120, `NX`=8, `NY`=7, `COLOR_DEPTH`=9.
  - Op encodings `OP_CELL`/`OP_CLEAR`.
  - Colour constants (black, background).
- One sub-module, `pixel_scan_counter`:
  - 2-D counter with runtime width/height (log2-sized), `start`, `step` and a `last` flag.
  - Wraps the inner counter to 0 and increments the outer.
  - Reused for both CELL and CLEAR.

## Test plan

- Reset, then idle 10 cycles → `write`=0, `done`=0, `req_ready`=1, `x`=`y`=`color`=0.
- Cell op, col=0, row=0, color=9'h1C0 → 64 writes, first (40,0), last (47,7), strictly raster order; `done` at k+65; no duplicate or missing pixels (scoreboard).
- Cell op, col=9, row=14 then immediately col=3, row=2 with `req_valid` held → first command ends at (119,119); second accepted in the `done` cycle; first pixel (64,16) follows with no idle gap beyond one cycle.
- Cell op, col=10, row=0 → zero writes, `done` at k+1, `req_ready` high throughout.
- Clear op, color=9'h000 → exactly 19200 writes covering (0,0)..(159,119), `done` at k+19201; `req_valid` pulses during the scan are ignored.
- Cell op, `resetn` low at pixel 20 → next cycle `write`=0, outputs at reset values, no `done`; a new command afterwards completes normally.
